// File: rtl/pb_hex_entry.sv
// Pushbutton hex-entry front end: synchronizes and debounces a bank of 19 keys,
// assembles up to two hex digits and commits them through a valid/ready handshake.
module pb_hex_entry #(
  parameter int DEB_CYCLES = 2
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  input  logic        ready,
  output logic [7:0]  value,
  output logic        valid,
  output logic [7:0]  entry,
  output logic [1:0]  count,
  output logic        key_strobe,
  output logic [4:0]  key_code
);

  localparam logic [4:0] DEB       = 5'(DEB_CYCLES);
  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_CLEAR = 5'd17;
  localparam logic [4:0] KEY_BKSP  = 5'd18;

  typedef enum logic [1:0] {IDLE, CHECK, HELD, WAIT_REL} state_t;

  state_t      r_state;
  logic [18:0] r_sync1;
  logic [18:0] r_sync2;
  logic [1:0]  r_fill;
  logic [4:0]  r_code;
  logic [3:0]  r_cnt;
  logic [7:0]  r_value;
  logic        r_valid;
  logic [7:0]  r_entry;
  logic [1:0]  r_count;
  logic        r_strobe;
  logic [4:0]  r_key_code;

  logic [4:0]  w_cand_code;
  logic        w_cand_any;
  logic [4:0]  w_cnt_inc;
  logic        w_accept;
  logic        w_unused;

  assign w_unused  = ^pb[20:19];
  assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

  // Lowest-index pressed key wins.
  always_comb begin
    w_cand_code = '0;
    w_cand_any  = 1'b0;
    for (int i = 18; i >= 0; i--) begin
      if (r_sync2[i]) begin
        w_cand_code = 5'(i);
        w_cand_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cand_any && (DEB <= 5'd1)) w_accept = 1'b1;
      end
      CHECK: begin
        if (w_cand_any) begin
          if (w_cand_code == r_code) w_accept = (w_cnt_inc >= DEB);
          else                       w_accept = (DEB <= 5'd1);
        end
      end
      default: w_accept = 1'b0;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= pb[18:0];
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  // WAIT_REL also waits for the synchronizer to refill after reset, so a key
  // held through reset release is never mistaken for a released bank.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_REL;
      r_code  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cand_any) begin
            r_code  <= w_cand_code;
            r_cnt   <= 4'd1;
            r_state <= w_accept ? HELD : CHECK;
          end
        end
        CHECK: begin
          if (!w_cand_any) begin
            r_state <= IDLE;
          end else if (w_cand_code == r_code) begin
            r_cnt <= w_cnt_inc[3:0];
            if (w_accept) r_state <= HELD;
          end else begin
            r_code <= w_cand_code;
            r_cnt  <= 4'd1;
            if (w_accept) r_state <= HELD;
          end
        end
        HELD, WAIT_REL: begin
          if (!w_cand_any && r_fill[1]) r_state <= IDLE;
        end
        default: r_state <= WAIT_REL;
      endcase
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_entry    <= '0;
      r_count    <= '0;
      r_strobe   <= 1'b0;
      r_key_code <= '0;
    end else begin
      r_strobe <= w_accept;
      if (r_valid && ready) r_valid <= 1'b0;
      if (w_accept) begin
        r_key_code <= w_cand_code;
        if (w_cand_code < KEY_ENTER) begin
          r_entry <= {r_entry[3:0], w_cand_code[3:0]};
          if (r_count != 2'd2) r_count <= r_count + 2'd1;
        end else if (w_cand_code == KEY_ENTER) begin
          // Enter looks at pre-edge valid, so a same-edge handshake wins.
          if ((r_count != 2'd0) && !r_valid) begin
            r_value <= r_entry;
            r_valid <= 1'b1;
            r_entry <= '0;
            r_count <= '0;
          end
        end else if (w_cand_code == KEY_CLEAR) begin
          r_entry <= '0;
          r_count <= '0;
        end else if (w_cand_code == KEY_BKSP) begin
          r_entry <= {4'h0, r_entry[7:4]};
          if (r_count != 2'd0) r_count <= r_count - 2'd1;
        end
      end
    end
  end

  assign value      = r_value;
  assign valid      = r_valid;
  assign entry      = r_entry;
  assign count      = r_count;
  assign key_strobe = r_strobe;
  assign key_code   = r_key_code;

endmodule

// File: tb/tb_pb_hex_entry.sv
// Directed bench for pb_hex_entry: debounce latency, digit entry, enter/handshake,
// clear/backspace, glitch rejection and reset behaviour with a held key.
module tb_pb_hex_entry;

  logic        hz100;
  logic        reset;
  logic [20:0] pb;
  logic        ready;
  logic [7:0]  value;
  logic        valid;
  logic [7:0]  entry;
  logic [1:0]  count;
  logic        key_strobe;
  logic [4:0]  key_code;

  int checks;
  int failures;

  pb_hex_entry #(.DEB_CYCLES(2)) dut (
    .hz100(hz100),
    .reset(reset),
    .pb(pb),
    .ready(ready),
    .value(value),
    .valid(valid),
    .entry(entry),
    .count(count),
    .key_strobe(key_strobe),
    .key_code(key_code)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // Presses pat after an edge e0, releases after edge e0+hold; ready pulses for the
  // edge following step rdy_at. first = index n of edge e0+n that raised key_strobe.
  task automatic press(input logic [20:0] pat, input int hold, input int rdy_at,
                       output int nstr, output int first);
    nstr  = 0;
    first = -1;
    @(posedge hz100); #1;
    pb = pat;
    for (int n = 1; n <= hold + 6; n++) begin
      @(posedge hz100); #1;
      if (key_strobe) begin
        nstr++;
        if (first < 0) first = n;
      end
      if (n == hold) pb = '0;
      ready = (n == rdy_at);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; pb = '0; ready = 1'b0;
    #12;
    checks++; if (value !== 8'h00)    begin failures++; $display("FAIL reset_value got=%h exp=00", value); end
    checks++; if (valid !== 1'b0)     begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (entry !== 8'h00)    begin failures++; $display("FAIL reset_entry got=%h exp=00", entry); end
    checks++; if (count !== 2'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (key_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", key_strobe); end
    checks++; if (key_code !== 5'd0)  begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    @(posedge hz100); #1;
    reset = 1'b1;
    repeat (5) @(posedge hz100);
    $display("test_reset: value=%h valid=%b entry=%h count=%0d", value, valid, entry, count);
  endtask

  task automatic test_digits;
    int nstr, first;
    press(21'd1 << 10, 6, -1, nstr, first);
    $display("press pb[10]: strobes=%0d first=%0d code=%0d entry=%h", nstr, first, key_code, entry);
    checks++; if (nstr !== 1)  begin failures++; $display("FAIL digA_strobes got=%0d exp=1", nstr); end
    checks++; if (first !== 4) begin failures++; $display("FAIL digA_latency got=%0d exp=4", first); end
    checks++; if (key_code !== 5'd10) begin failures++; $display("FAIL digA_code got=%0d exp=10", key_code); end
    press(21'd1 << 3, 6, -1, nstr, first);
    $display("press pb[3]: strobes=%0d first=%0d entry=%h count=%0d", nstr, first, entry, count);
    checks++; if (nstr !== 1)  begin failures++; $display("FAIL dig3_strobes got=%0d exp=1", nstr); end
    checks++; if (first !== 4) begin failures++; $display("FAIL dig3_latency got=%0d exp=4", first); end
    checks++; if (entry !== 8'hA3) begin failures++; $display("FAIL dig3_entry got=%h exp=a3", entry); end
    checks++; if (count !== 2'd2)  begin failures++; $display("FAIL dig3_count got=%0d exp=2", count); end
  endtask

  task automatic test_enter;
    int nstr, first;
    press(21'd1 << 16, 6, -1, nstr, first);
    $display("enter: value=%h valid=%b entry=%h count=%0d", value, valid, entry, count);
    checks++; if (value !== 8'hA3) begin failures++; $display("FAIL enter_value got=%h exp=a3", value); end
    checks++; if (valid !== 1'b1)  begin failures++; $display("FAIL enter_valid got=%b exp=1", valid); end
    checks++; if (entry !== 8'h00) begin failures++; $display("FAIL enter_entry got=%h exp=00", entry); end
    checks++; if (count !== 2'd0)  begin failures++; $display("FAIL enter_count got=%0d exp=0", count); end
    press(21'd1 << 5, 6, -1, nstr, first);
    press(21'd1 << 16, 6, -1, nstr, first);
    $display("enter while valid: strobes=%0d value=%h valid=%b entry=%h count=%0d", nstr, value, valid, entry, count);
    checks++; if (nstr !== 1)      begin failures++; $display("FAIL enter2_strobes got=%0d exp=1", nstr); end
    checks++; if (value !== 8'hA3) begin failures++; $display("FAIL enter2_value got=%h exp=a3", value); end
    checks++; if (valid !== 1'b1)  begin failures++; $display("FAIL enter2_valid got=%b exp=1", valid); end
    checks++; if (entry !== 8'h05) begin failures++; $display("FAIL enter2_entry got=%h exp=05", entry); end
    checks++; if (count !== 2'd1)  begin failures++; $display("FAIL enter2_count got=%0d exp=1", count); end
  endtask

  task automatic test_handshake;
    @(posedge hz100); #1;
    ready = 1'b1;
    @(posedge hz100); #1;
    ready = 1'b0;
    $display("handshake: value=%h valid=%b", value, valid);
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL hs_valid got=%b exp=0", valid); end
    checks++; if (value !== 8'hA3) begin failures++; $display("FAIL hs_value got=%h exp=a3", value); end
  endtask

  task automatic test_glitch;
    int nstr, first, glitches;
    glitches = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge hz100); #1;
      if (key_strobe) glitches++;
      pb = (n % 2 == 0) ? (21'd1 << 2) : 21'd0;
    end
    pb = '0;
    for (int n = 0; n < 6; n++) begin
      @(posedge hz100); #1;
      if (key_strobe) glitches++;
    end
    $display("toggle pb[2]: strobes=%0d", glitches);
    checks++; if (glitches !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", glitches); end
    press((21'd1 << 2) | (21'd1 << 7), 6, -1, nstr, first);
    $display("press pb[2]+pb[7]: strobes=%0d code=%0d entry=%h", nstr, key_code, entry);
    checks++; if (nstr !== 1)        begin failures++; $display("FAIL multi_strobes got=%0d exp=1", nstr); end
    checks++; if (key_code !== 5'd2) begin failures++; $display("FAIL multi_code got=%0d exp=2", key_code); end
    checks++; if (entry !== 8'h52)   begin failures++; $display("FAIL multi_entry got=%h exp=52", entry); end
  endtask

  task automatic test_backspace;
    int nstr, first;
    logic [7:0] exp_e [3];
    logic [1:0] exp_c [3];
    exp_e[0] = 8'h02; exp_e[1] = 8'h00; exp_e[2] = 8'h00;
    exp_c[0] = 2'd1;  exp_c[1] = 2'd0;  exp_c[2] = 2'd0;
    press(21'd1 << 17, 6, -1, nstr, first);
    $display("clear: entry=%h count=%0d value=%h", entry, count, value);
    checks++; if (entry !== 8'h00) begin failures++; $display("FAIL clear_entry got=%h exp=00", entry); end
    checks++; if (count !== 2'd0)  begin failures++; $display("FAIL clear_count got=%0d exp=0", count); end
    checks++; if (value !== 8'hA3) begin failures++; $display("FAIL clear_value got=%h exp=a3", value); end
    press(21'd1 << 1, 6, -1, nstr, first);
    press(21'd1 << 2, 6, -1, nstr, first);
    press(21'd1 << 3, 6, -1, nstr, first);
    $display("digits 1,2,3: entry=%h count=%0d", entry, count);
    checks++; if (entry !== 8'h23) begin failures++; $display("FAIL d123_entry got=%h exp=23", entry); end
    checks++; if (count !== 2'd2)  begin failures++; $display("FAIL d123_count got=%0d exp=2", count); end
    for (int i = 0; i < 3; i++) begin
      press(21'd1 << 18, 6, -1, nstr, first);
      $display("backspace %0d: entry=%h count=%0d", i, entry, count);
      checks++; if (entry !== exp_e[i]) begin failures++; $display("FAIL bksp%0d_entry got=%h exp=%h", i, entry, exp_e[i]); end
      checks++; if (count !== exp_c[i]) begin failures++; $display("FAIL bksp%0d_count got=%0d exp=%0d", i, count, exp_c[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int nstr, first;
    press(21'd1 << 7, 6, -1, nstr, first);
    press(21'd1 << 16, 6, -1, nstr, first);
    press(21'd1 << 8, 6, -1, nstr, first);
    checks++; if (value !== 8'h07) begin failures++; $display("FAIL b2b_commit got=%h exp=07", value); end
    press(21'd1 << 16, 6, 3, nstr, first);
    $display("enter with handshake: strobes=%0d value=%h valid=%b entry=%h count=%0d", nstr, value, valid, entry, count);
    checks++; if (nstr !== 1)      begin failures++; $display("FAIL b2b_strobes got=%0d exp=1", nstr); end
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL b2b_valid got=%b exp=0", valid); end
    checks++; if (value !== 8'h07) begin failures++; $display("FAIL b2b_value got=%h exp=07", value); end
    checks++; if (entry !== 8'h08) begin failures++; $display("FAIL b2b_entry got=%h exp=08", entry); end
    checks++; if (count !== 2'd1)  begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
  endtask

  task automatic test_reset_mid;
    int nstr, first, held;
    held = 0;
    @(posedge hz100); #1;
    pb = 21'd1 << 4;
    repeat (3) @(posedge hz100);
    #1;
    reset = 1'b0;
    #1;
    $display("reset mid-check: value=%h valid=%b entry=%h count=%0d strobe=%b code=%0d", value, valid, entry, count, key_strobe, key_code);
    checks++; if (value !== 8'h00)  begin failures++; $display("FAIL rmid_value got=%h exp=00", value); end
    checks++; if (entry !== 8'h00)  begin failures++; $display("FAIL rmid_entry got=%h exp=00", entry); end
    checks++; if (count !== 2'd0)   begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
    checks++; if (key_code !== 5'd0) begin failures++; $display("FAIL rmid_code got=%0d exp=0", key_code); end
    repeat (2) @(posedge hz100);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge hz100); #1;
      if (key_strobe) held++;
    end
    pb = '0;
    for (int n = 0; n < 6; n++) begin
      @(posedge hz100); #1;
      if (key_strobe) held++;
    end
    $display("held through reset: strobes=%0d", held);
    checks++; if (held !== 0) begin failures++; $display("FAIL rmid_held_strobes got=%0d exp=0", held); end
    press(21'd1 << 4, 6, -1, nstr, first);
    $display("re-press pb[4]: strobes=%0d first=%0d code=%0d entry=%h", nstr, first, key_code, entry);
    checks++; if (nstr !== 1)        begin failures++; $display("FAIL rmid_repress_strobes got=%0d exp=1", nstr); end
    checks++; if (first !== 4)       begin failures++; $display("FAIL rmid_repress_latency got=%0d exp=4", first); end
    checks++; if (key_code !== 5'd4) begin failures++; $display("FAIL rmid_repress_code got=%0d exp=4", key_code); end
    checks++; if (entry !== 8'h04)   begin failures++; $display("FAIL rmid_repress_entry got=%h exp=04", entry); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_digits;
    test_enter;
    test_handshake;
    test_glitch;
    test_backspace;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pb_hex_entry.md
PB_HEX_ENTRY -- requirements
Module: pb_hex_entry

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 2: consecutive stable synchronized samples (range 1-15) required to accept a key.
REQ-002 The block SHALL have port hz100, input, 1: the single system clock; all flops are clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port pb, input, 21: raw pushbuttons; pb[15:0]=hex digits 0-F, pb[16]=enter, pb[17]=clear, pb[18]=backspace, pb[20:19] ignored.
REQ-005 The block SHALL have port ready, input, 1: consumer accepts value when high at a clock edge with valid high.
REQ-006 The block SHALL have port value, output, 8: committed two-digit entry.
REQ-007 The block SHALL have port valid, output, 1: value is available.
REQ-008 The block SHALL have port entry, output, 8: in-progress digits, for display.
REQ-009 The block SHALL have port count, output, 2: number of digits in entry (0-2).
REQ-010 The block SHALL have port key_strobe, output, 1: one-cycle pulse per accepted key.
REQ-011 The block SHALL have port key_code, output, 5: index of the last accepted key.

Function
REQ-012 The block SHALL pass pb[18:0] through a 2-flop synchronizer before any other use.
REQ-013 The block SHALL form the candidate code as the lowest set index of synchronized pb[18:0]; none set = released.
REQ-014 The FSM SHALL have states IDLE, CHECK, HELD, WAIT_REL.
REQ-015 IDLE: candidate present -> CHECK, load code, stability counter=1.
REQ-016 CHECK, same code: counter increments; on reaching DEB_CYCLES -> HELD and accept the key (key_strobe=1 that cycle).
REQ-017 CHECK, different non-zero code: stay in CHECK, reload code, counter=1; all released: -> IDLE, no strobe.
REQ-018 HELD and WAIT_REL: -> IDLE only after all keys have been released for one sample; no auto-repeat, and other keys pressed meanwhile are ignored.
REQ-019 With pb held constant from edge k, key_strobe SHALL be high in the cycle after edge k+2+DEB_CYCLES (k+4 at default).
REQ-020 entry, count, value, valid and key_code SHALL update on the same edge that raises key_strobe.
REQ-021 Digit d: entry<={entry[3:0],d}; count saturates at 2 (third digit shifts out the oldest).
REQ-022 Enter with count!=0 and valid low (pre-edge): value<=entry, valid<=1, entry<=0, count<=0.
REQ-023 Enter with count==0 or valid high SHALL be ignored; entry and count are kept.
REQ-024 Clear: entry<=0, count<=0; valid and value unaffected.
REQ-025 Backspace: entry<=entry>>4; count decrements and saturates at 0.
REQ-026 valid SHALL drop on the edge where valid and ready are both high; value is held stable while valid is high.
REQ-027 Handshake and enter on the same edge: handshake completes, enter is ignored (it sees pre-edge valid=1).

Reset
REQ-028 Reset low SHALL immediately force value=0, valid=0, entry=0, count=0, key_strobe=0, key_code=0, synchronizer=0, counter=0, FSM=WAIT_REL.
REQ-029 A key held across reset release SHALL NOT be accepted until it is released and pressed again.

Verification
REQ-030 Press pb[10] for 6 cycles, release; then pb[3] -> one strobe each, strobe 4 cycles after press edge (DEB=2), entry=8'hA3, count=2.
REQ-031 Press pb[16], ready=0 -> value=8'hA3, valid=1, entry=0; a second enter after digit 5 -> ignored, entry=8'h05.
REQ-032 ready=1 for one cycle -> valid=0 next edge; value unchanged at 8'hA3.
REQ-033 pb[2] toggling every cycle for 10 cycles -> no key_strobe; then pb[2] and pb[7] together held -> key_code=2, single strobe.
REQ-034 Digits 1,2,3 then backspace twice, backspace again -> entry 8'h23, 8'h02, 8'h00; count 2,1,0,0.
REQ-035 Reset asserted mid-CHECK with pb[4] held, released while still held -> no strobe until pb released and re-pressed; all outputs 0.
